// File: rtl/dec_pkg.sv
// Shared constants for the 5-to-32 decoder and the 32-to-5 onehot encoder.
package dec_pkg;
   localparam int N_LINES   = 32;
   localparam int A_W       = 5;
   localparam int GROUP     = 8;
   localparam int ERR_CNT_W = 8;
endpackage

// File: rtl/onehot_encoder_enc_group.sv
// Combinational LSB-priority encoder for one GROUP-bit slice of the input vector.
module enc_group #(
   parameter  int GROUP = 8,
   localparam int L_W   = $clog2(GROUP)
) (
   input  logic [GROUP-1:0] d_i,
   output logic             any_o,
   output logic             multi_o,
   output logic [L_W-1:0]   idx_o
);

   always_comb begin
      any_o   = |d_i;
      // Clearing the lowest set bit leaves something only if two or more were set.
      multi_o = |(d_i & (d_i - GROUP'(1)));
      idx_o   = '0;
      for (int i = GROUP - 1; i >= 0; i--) begin
         if (d_i[i]) idx_o = L_W'(i);
      end
   end

endmodule

// File: rtl/onehot_encoder.sv
// Registered 32-to-5 onehot encoder: group encoders feed stage 1, the combine feeds stage 2,
// with valid/ready on both sides and a saturating count of zero/multi-hot results.
module onehot_encoder
   import dec_pkg::*;
#(
   parameter int N_IN      = N_LINES,
   parameter int GROUP     = dec_pkg::GROUP,
   parameter int A_W       = $clog2(N_IN),
   parameter int ERR_CNT_W = dec_pkg::ERR_CNT_W
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [N_IN-1:0]      D,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [A_W-1:0]       A,
   output logic                 out_zero,
   output logic                 out_multi,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam int NG  = N_IN / GROUP;
   localparam int L_W = $clog2(GROUP);
   localparam int G_W = A_W - L_W;

   logic [NG-1:0]  g_any, g_multi;
   logic [L_W-1:0] g_idx [NG];

   for (genvar g = 0; g < NG; g++) begin : gen_grp
      enc_group #(.GROUP(GROUP)) u_grp (
         .d_i     (D[g*GROUP +: GROUP]),
         .any_o   (g_any[g]),
         .multi_o (g_multi[g]),
         .idx_o   (g_idx[g])
      );
   end

   logic                 s1_valid_q, s1_valid_d;
   logic [NG-1:0]        s1_any_q, s1_multi_q;
   logic [L_W-1:0]       s1_idx_q [NG];
   logic                 s2_valid_q, s2_valid_d;
   logic [A_W-1:0]       a_q, a_d;
   logic                 zero_q, zero_d, multi_q, multi_d;
   logic [ERR_CNT_W-1:0] err_q, err_d;
   logic                 s1_load, s2_load, out_xfer;
   logic [G_W-1:0]       sel;

   assign s2_load  = s1_valid_q & (~s2_valid_q | out_ready);
   assign in_ready = ~s1_valid_q | s2_load;
   assign s1_load  = in_valid & in_ready;
   assign out_xfer = s2_valid_q & out_ready;

   // Stage 1 -> stage 2: pick the lowest populated group and splice its local index.
   always_comb begin
      sel = '0;
      for (int g = NG - 1; g >= 0; g--) begin
         if (s1_any_q[g]) sel = G_W'(g);
      end
      a_d     = {sel, s1_idx_q[sel]};
      zero_d  = ~|s1_any_q;
      multi_d = (|s1_multi_q) | (|(s1_any_q & (s1_any_q - NG'(1))));

      s1_valid_d = s1_valid_q;
      if (s1_load)      s1_valid_d = 1'b1;
      else if (s2_load) s1_valid_d = 1'b0;

      s2_valid_d = s2_valid_q;
      if (s2_load)       s2_valid_d = 1'b1;
      else if (out_xfer) s2_valid_d = 1'b0;

      err_d = err_q;
      if (out_xfer && (zero_q || multi_q) && !(&err_q)) err_d = err_q + ERR_CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (s1_load) begin
         s1_any_q   <= g_any;
         s1_multi_q <= g_multi;
         s1_idx_q   <= g_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         a_q        <= '0;
         zero_q     <= 1'b0;
         multi_q    <= 1'b0;
         err_q      <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         err_q      <= err_d;
         if (s2_load) begin
            a_q     <= a_d;
            zero_q  <= zero_d;
            multi_q <= multi_d;
         end
      end
   end

   assign out_valid = s2_valid_q;
   assign A         = a_q;
   assign out_zero  = zero_q;
   assign out_multi = multi_q;
   assign err_count = err_q;

endmodule

// File: tb/tb_onehot_encoder.sv
// Directed bench for onehot_encoder, including a round trip through a bench-side decoder.
module tb_onehot_encoder;

   logic        clk;
   logic        rst;
   logic        in_valid, in_valid_drv;
   logic        in_ready;
   logic [31:0] D, d_drv;
   logic        out_valid;
   logic        out_ready;
   logic [4:0]  A;
   logic        out_zero, out_multi;
   logic [7:0]  err_count;

   logic        use_dec;
   logic        dec_en, dec_vld_q;
   logic [4:0]  a_dec;
   logic [31:0] dec_q;

   int tests_run = 0;
   int tests_failed = 0;

   onehot_encoder dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .D         (D),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .A         (A),
      .out_zero  (out_zero),
      .out_multi (out_multi),
      .err_count (err_count)
   );

   // Registered 5-to-32 decoder, one cycle of latency.
   always_ff @(posedge clk) begin
      dec_q     <= 32'd1 << a_dec;
      dec_vld_q <= dec_en;
   end

   assign D        = use_dec ? dec_q : d_drv;
   assign in_valid = use_dec ? dec_vld_q : in_valid_drv;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      in_valid_drv = 1'b0;
      out_ready = 1'b0;
      use_dec = 1'b0;
      dec_en = 1'b0;
      d_drv = '0;
      next_cycle();
      next_cycle();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      apply_reset();
      @(negedge clk);
      tests_run++;
      if ({out_valid, A, out_zero, out_multi, err_count, in_ready} !== {1'b0, 5'd0, 1'b0, 1'b0, 8'd0, 1'b1}) begin
         tests_failed++;
         $display("FAIL reset_state: got vld=%b A=%0d z=%b m=%b err=%0d rdy=%b, want vld=0 A=0 z=0 m=0 err=0 rdy=1",
                  out_valid, A, out_zero, out_multi, err_count, in_ready);
      end
      next_cycle();
   endtask

   task automatic test_sweep();
      apply_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 35; c++) begin
         in_valid_drv = (c < 32);
         d_drv = (c < 32) ? (32'd1 << c) : 32'd0;
         @(negedge clk);
         tests_run++;
         if (in_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL sweep_in_ready c=%0d: got %b want 1", c, in_ready);
         end
         tests_run++;
         if (c >= 2 && c < 34) begin
            if ({out_valid, A, out_zero, out_multi} !== {1'b1, 5'(c - 2), 2'b00}) begin
               tests_failed++;
               $display("FAIL sweep_out c=%0d: got vld=%b A=%0d z=%b m=%b, want vld=1 A=%0d z=0 m=0",
                        c, out_valid, A, out_zero, out_multi, c - 2);
            end
         end else if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL sweep_idle c=%0d: got vld=%b want 0", c, out_valid);
         end
         next_cycle();
      end
      tests_run++;
      if (err_count !== 8'd0) begin
         tests_failed++;
         $display("FAIL sweep_err: got %0d want 0", err_count);
      end
   endtask

   task automatic test_flags();
      logic [31:0] vec [3] = '{32'h0000_0000, 32'h8000_0001, 32'h0000_0300};
      logic [4:0]  ea  [3] = '{5'd0, 5'd0, 5'd8};
      logic        ez  [3] = '{1'b1, 1'b0, 1'b0};
      logic        em  [3] = '{1'b0, 1'b1, 1'b1};
      apply_reset();
      out_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         in_valid_drv = (c < 3);
         d_drv = (c < 3) ? vec[c] : 32'd0;
         @(negedge clk);
         if (c >= 2 && c < 5) begin
            tests_run++;
            if ({out_valid, A, out_zero, out_multi} !== {1'b1, ea[c-2], ez[c-2], em[c-2]}) begin
               tests_failed++;
               $display("FAIL flags_out v=%0d: got vld=%b A=%0d z=%b m=%b, want vld=1 A=%0d z=%b m=%b",
                        c - 2, out_valid, A, out_zero, out_multi, ea[c-2], ez[c-2], em[c-2]);
            end
         end
         if (c == 4) begin
            tests_run++;
            if (err_count !== 8'd2) begin
               tests_failed++;
               $display("FAIL flags_err2: got %0d want 2", err_count);
            end
         end
         if (c == 5) begin
            tests_run++;
            if (err_count !== 8'd3) begin
               tests_failed++;
               $display("FAIL flags_err3: got %0d want 3", err_count);
            end
         end
         next_cycle();
      end
   endtask

   task automatic test_back_to_back_stall();
      logic [31:0] vec [5] = '{32'd1 << 3, 32'd1 << 17, 32'd1 << 0, 32'd1 << 31, 32'd1 << 9};
      logic [4:0]  ea  [5] = '{5'd3, 5'd17, 5'd0, 5'd31, 5'd9};
      int ptr = 0;
      int rcv = 0;
      apply_reset();
      for (int c = 0; c < 20; c++) begin
         in_valid_drv = (ptr < 5);
         d_drv = (ptr < 5) ? vec[ptr] : 32'd0;
         out_ready = !(c >= 3 && c < 6);
         @(negedge clk);
         if (c >= 3 && c < 6) begin
            tests_run++;
            if ({in_ready, out_valid, A} !== {1'b0, 1'b1, 5'd17}) begin
               tests_failed++;
               $display("FAIL stall_hold c=%0d: got rdy=%b vld=%b A=%0d, want rdy=0 vld=1 A=17",
                        c, in_ready, out_valid, A);
            end
         end
         if (out_valid && out_ready) begin
            tests_run++;
            if (rcv >= 5) begin
               tests_failed++;
               $display("FAIL stall_extra c=%0d: got extra output A=%0d, want none", c, A);
            end else if ({A, out_zero, out_multi} !== {ea[rcv], 2'b00}) begin
               tests_failed++;
               $display("FAIL stall_order n=%0d: got A=%0d z=%b m=%b, want A=%0d z=0 m=0",
                        rcv, A, out_zero, out_multi, ea[rcv]);
            end
            rcv++;
         end
         if (in_valid && in_ready) ptr++;
         next_cycle();
      end
      tests_run++;
      if (rcv !== 5) begin
         tests_failed++;
         $display("FAIL stall_count: got %0d delivered want 5", rcv);
      end
   endtask

   task automatic test_roundtrip();
      apply_reset();
      out_ready = 1'b1;
      use_dec = 1'b1;
      for (int c = 0; c < 35; c++) begin
         a_dec = 5'(c);
         dec_en = (c < 32);
         @(negedge clk);
         if (c >= 3) begin
            tests_run++;
            if ({out_valid, A, out_zero, out_multi} !== {1'b1, 5'(c - 3), 2'b00}) begin
               tests_failed++;
               $display("FAIL roundtrip a_dec=%0d: got vld=%b A=%0d z=%b m=%b, want vld=1 A=%0d z=0 m=0",
                        c - 3, out_valid, A, out_zero, out_multi, c - 3);
            end
         end
         next_cycle();
      end
      dec_en = 1'b0;
      use_dec = 1'b0;
   endtask

   task automatic test_saturate();
      apply_reset();
      out_ready = 1'b1;
      d_drv = 32'd0;
      for (int c = 0; c < 303; c++) begin
         in_valid_drv = (c < 300);
         @(negedge clk);
         if (c == 100) begin
            tests_run++;
            if (err_count !== 8'd98) begin
               tests_failed++;
               $display("FAIL sat_mid: got %0d want 98", err_count);
            end
         end
         if (c == 260 || c == 302) begin
            tests_run++;
            if (err_count !== 8'hFF) begin
               tests_failed++;
               $display("FAIL sat_hold c=%0d: got %0d want 255", c, err_count);
            end
         end
         next_cycle();
      end
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({err_count, out_valid} !== {8'd0, 1'b0}) begin
         tests_failed++;
         $display("FAIL sat_reset: got err=%0d vld=%b want err=0 vld=0", err_count, out_valid);
      end
      next_cycle();
   endtask

   task automatic test_reset_flush();
      apply_reset();
      out_ready = 1'b0;
      in_valid_drv = 1'b1;
      d_drv = 32'd1 << 4;
      next_cycle();
      d_drv = 32'd1 << 5;
      next_cycle();
      in_valid_drv = 1'b0;
      d_drv = 32'd0;
      @(negedge clk);
      tests_run++;
      if ({out_valid, A, in_ready} !== {1'b1, 5'd4, 1'b0}) begin
         tests_failed++;
         $display("FAIL flush_full: got vld=%b A=%0d rdy=%b want vld=1 A=4 rdy=0", out_valid, A, in_ready);
      end
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      tests_run++;
      if ({out_valid, A} !== {1'b0, 5'd0}) begin
         tests_failed++;
         $display("FAIL flush_reset: got vld=%b A=%0d want vld=0 A=0", out_valid, A);
      end
      for (int c = 0; c < 5; c++) begin
         next_cycle();
         @(negedge clk);
         tests_run++;
         if (out_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_stale c=%0d: got vld=%b A=%0d want vld=0", c, out_valid, A);
         end
      end
      next_cycle();
   endtask

   initial begin
      rst = 1'b1;
      in_valid_drv = 1'b0;
      out_ready = 1'b0;
      use_dec = 1'b0;
      dec_en = 1'b0;
      a_dec = '0;
      d_drv = '0;
      @(posedge clk);
      #1;
      test_reset();
      test_sweep();
      test_flags();
      test_back_to_back_stall();
      test_roundtrip();
      test_saturate();
      test_reset_flush();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
